// File: rtl/ht1632_frame_rx_if.sv
// Link and framebuffer-side signals of the HT1632 frame receiver.
// master = link driver / reader, slave = receiver.
interface ht1632_frame_rx_if #(
  parameter int ADDR_W = 7
);
  logic              cs;
  logic              write;
  logic              data;
  logic [ADDR_W-1:0] rd_addr;
  logic [3:0]        rd_data;
  logic              frame_done;
  logic [ADDR_W-1:0] frame_nibs;
  logic              cmd_valid;
  logic [7:0]        cmd_code;
  logic [2:0]        err;

  modport master (
    output cs, write, data, rd_addr,
    input  rd_data, frame_done, frame_nibs, cmd_valid, cmd_code, err
  );

  modport slave (
    input  cs, write, data, rd_addr,
    output rd_data, frame_done, frame_nibs, cmd_valid, cmd_code, err
  );
endinterface

// File: rtl/ht1632_frame_rx.sv
// Receiver for the cs/write/data matrix link: write frames fill a nibble framebuffer, command frames report codes.
// Define HT_RX_DOUBLE_BUF_EN for a front/back framebuffer that swaps on frame_done.
module ht1632_frame_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int NIBBLES     = 96,
  parameter int ADDR_W      = 7
) (
  input logic              clk,
  input logic              RST,
  ht1632_frame_rx_if.slave bus
);

`ifdef HT_RX_DOUBLE_BUF_EN
  localparam int BANKS = 2;
`else
  localparam int BANKS = 1;
`endif
  localparam int DEPTH = BANKS * NIBBLES;
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, ID, ADDR, DATA, CMD, DISCARD} state_t;

  logic [SYNC_STAGES-1:0] cs_sh, wr_sh, dat_sh;
  logic                   cs_d, wr_d;
  logic                   cs_s, wr_s, dat_s;
  logic                   cs_fall, cs_rise, bit_ev;

  state_t            state, state_n;
  logic [3:0]        bit_cnt, bit_cnt_n;
  logic [7:0]        shreg, shreg_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [ADDR_W-1:0] nib_cnt, nib_cnt_n;
  logic              wr_en, wr_en_n;
  logic [IDX_W-1:0]  wr_idx, wr_idx_n;
  logic [3:0]        wr_nib, wr_nib_n;
  logic              frame_done, frame_done_n;
  logic [ADDR_W-1:0] frame_nibs, frame_nibs_n;
  logic              cmd_valid, cmd_valid_n;
  logic [7:0]        cmd_code, cmd_code_n;
  logic [2:0]        err, err_n;
  int                wr_base, rd_base;

  logic [3:0] mem [DEPTH];

  // cs idles high so the synchroniser must reset to 1 to avoid a phantom frame start
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      cs_sh  <= '1;
      wr_sh  <= '0;
      dat_sh <= '0;
      cs_d   <= 1'b1;
      wr_d   <= 1'b0;
    end else begin
      cs_sh  <= {cs_sh[SYNC_STAGES-2:0], bus.cs};
      wr_sh  <= {wr_sh[SYNC_STAGES-2:0], bus.write};
      dat_sh <= {dat_sh[SYNC_STAGES-2:0], bus.data};
      cs_d   <= cs_sh[SYNC_STAGES-1];
      wr_d   <= wr_sh[SYNC_STAGES-1];
    end
  end

  assign cs_s    = cs_sh[SYNC_STAGES-1];
  assign wr_s    = wr_sh[SYNC_STAGES-1];
  assign dat_s   = dat_sh[SYNC_STAGES-1];
  assign cs_fall = cs_d & ~cs_s;
  assign cs_rise = ~cs_d & cs_s;
  assign bit_ev  = wr_s & ~wr_d & ~cs_s;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      addr       <= '0;
      nib_cnt    <= '0;
      wr_en      <= 1'b0;
      wr_idx     <= '0;
      wr_nib     <= '0;
      frame_done <= 1'b0;
      frame_nibs <= '0;
      cmd_valid  <= 1'b0;
      cmd_code   <= '0;
      err        <= '0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      addr       <= addr_n;
      nib_cnt    <= nib_cnt_n;
      wr_en      <= wr_en_n;
      wr_idx     <= wr_idx_n;
      wr_nib     <= wr_nib_n;
      frame_done <= frame_done_n;
      frame_nibs <= frame_nibs_n;
      cmd_valid  <= cmd_valid_n;
      cmd_code   <= cmd_code_n;
      err        <= err_n;
    end
  end

  // shreg holds the bits already received in the current field, so a field completes from shreg plus the new bit
  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    shreg_n      = shreg;
    addr_n       = addr;
    nib_cnt_n    = nib_cnt;
    wr_en_n      = 1'b0;
    wr_idx_n     = wr_idx;
    wr_nib_n     = wr_nib;
    frame_done_n = 1'b0;
    frame_nibs_n = frame_nibs;
    cmd_valid_n  = 1'b0;
    cmd_code_n   = cmd_code;
    err_n        = err;
    if (cs_rise) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
      nib_cnt_n = '0;
      if (state == DATA) begin
        if (nib_cnt != '0) begin
          frame_done_n = 1'b1;
          frame_nibs_n = nib_cnt;
        end
        if (bit_cnt != '0) err_n[1] = 1'b1;
      end
    end else if (state == IDLE) begin
      if (cs_fall) state_n = ID;
    end else if (bit_ev) begin
      shreg_n   = {shreg[6:0], dat_s};
      bit_cnt_n = bit_cnt + 4'd1;
      case (state)
        ID: begin
          if (bit_cnt == 4'd2) begin
            bit_cnt_n = '0;
            if ({shreg[1:0], dat_s} == 3'b101) state_n = ADDR;
            else if ({shreg[1:0], dat_s} == 3'b100) state_n = CMD;
            else begin
              state_n  = DISCARD;
              err_n[0] = 1'b1;
            end
          end
        end
        ADDR: begin
          if (bit_cnt == 4'(ADDR_W - 1)) begin
            bit_cnt_n = '0;
            addr_n    = {shreg[ADDR_W-2:0], dat_s};
            state_n   = DATA;
          end
        end
        DATA: begin
          if (bit_cnt == 4'd3) begin
            bit_cnt_n = '0;
            addr_n    = addr + ADDR_W'(1);
            if (int'(nib_cnt) < NIBBLES) nib_cnt_n = nib_cnt + ADDR_W'(1);
            if (int'(addr) < NIBBLES) begin
              wr_en_n  = 1'b1;
              wr_idx_n = IDX_W'(wr_base + int'(addr));
              wr_nib_n = {shreg[2:0], dat_s};
            end else begin
              err_n[2] = 1'b1;
            end
          end
        end
        CMD: begin
          if (bit_cnt == 4'd8) begin
            bit_cnt_n   = '0;
            cmd_code_n  = shreg;
            cmd_valid_n = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HT_RX_DOUBLE_BUF_EN
  logic front;

  // front flips on the same edge that raises frame_done, so the pulse and the new image appear together
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) front <= 1'b0;
    else      front <= front ^ frame_done_n;
  end

  assign wr_base = front ? 0 : NIBBLES;
  assign rd_base = front ? NIBBLES : 0;
`else
  assign wr_base = 0;
  assign rd_base = 0;
`endif

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_nib;
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST)                              bus.rd_data <= '0;
    else if (int'(bus.rd_addr) < NIBBLES)  bus.rd_data <= mem[IDX_W'(rd_base + int'(bus.rd_addr))];
    else                                   bus.rd_data <= '0;
  end

  assign bus.frame_done = frame_done;
  assign bus.frame_nibs = frame_nibs;
  assign bus.cmd_valid  = cmd_valid;
  assign bus.cmd_code   = cmd_code;
  assign bus.err        = err;

endmodule

// File: tb/tb_ht1632_frame_rx.sv
// Randomised and directed frame traffic for ht1632_frame_rx, checked against a frame-level model.
module tb_ht1632_frame_rx;
  localparam int ADDR_W  = 7;
  localparam int NIBBLES = 96;

  logic clk = 1'b0;
  logic RST = 1'b0;

  ht1632_frame_rx_if #(.ADDR_W(ADDR_W)) bus ();

  ht1632_frame_rx #(.SYNC_STAGES(2), .NIBBLES(NIBBLES), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int done_cnt   = 0;
  int exp_done   = 0;
  int exp_nibs   = 0;
  int exp_err    = 0;
  int front      = 0;
  int cmd_q[$];
  int exp_cmd[$];
  bit stim[$];
  bit pat[$];
  int mval[2][NIBBLES];
  bit mknown[2][NIBBLES];

  // pulses are captured on the falling edge, away from the edge that changes them
  always @(negedge clk) begin
    if (bus.frame_done) done_cnt++;
    if (bus.cmd_valid) cmd_q.push_back(int'(bus.cmd_code));
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int bits_val(input int start, input int len);
    int v = 0;
    for (int i = 0; i < len; i++) v = v * 2 + int'(stim[start + i]);
    return v;
  endfunction

  task automatic push_pat(input int v, input int len);
    for (int i = len - 1; i >= 0; i--) pat.push_back(bit'((v >> i) & 1));
  endtask

  task automatic read_nib(input int a, output int v);
    @(negedge clk);
    bus.rd_addr = ADDR_W'(a);
    @(posedge clk);
    #1 v = int'(bus.rd_data);
  endtask

  task automatic frame_start();
    stim.delete();
    @(negedge clk);
    bus.cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bit(input bit b);
    stim.push_back(b);
    bus.data  = b;
    bus.write = 1'b0;
    repeat (2) @(negedge clk);
    bus.write = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_val(input int v, input int len);
    for (int i = len - 1; i >= 0; i--) send_bit(bit'((v >> i) & 1));
  endtask

  // Frame-level effect of the bits sent inside one cs window
  task automatic model_frame();
    int n = stim.size();
    int id, a, full, rem, cnt, back;
    if (n < 3) return;
    id = bits_val(0, 3);
    if (id == 5) begin
      if (n < 10) return;
      a    = bits_val(3, 7);
      full = (n - 10) / 4;
      rem  = (n - 10) % 4;
`ifdef HT_RX_DOUBLE_BUF_EN
      back = 1 - front;
`else
      back = front;
`endif
      for (int k = 0; k < full; k++) begin
        int wa = (a + k) % 128;
        if (wa < NIBBLES) begin
          mval[back][wa]   = bits_val(10 + 4 * k, 4);
          mknown[back][wa] = 1'b1;
        end else begin
          exp_err = exp_err | 4;
        end
      end
      if (rem != 0) exp_err = exp_err | 2;
      cnt = (full > NIBBLES) ? NIBBLES : full;
      if (cnt > 0) begin
        exp_done++;
        exp_nibs = cnt;
        front = back;
      end
    end else if (id == 4) begin
      for (int k = 0; 3 + 9 * (k + 1) <= n; k++) exp_cmd.push_back(bits_val(3 + 9 * k, 8));
    end else begin
      exp_err = exp_err | 1;
    end
  endtask

  task automatic check_frame();
    int v;
    checkOutput("done_count", done_cnt, exp_done);
    checkOutput("frame_nibs", int'(bus.frame_nibs), exp_nibs);
    checkOutput("cmd_count", cmd_q.size(), exp_cmd.size());
    for (int i = 0; i < exp_cmd.size() && i < cmd_q.size(); i++)
      checkOutput("cmd_code", cmd_q[i], exp_cmd[i]);
    checkOutput("err", int'(bus.err), exp_err);
    cmd_q.delete();
    exp_cmd.delete();
    for (int a = 0; a < NIBBLES; a++) begin
      read_nib(a, v);
      if (mknown[front][a]) checkOutput($sformatf("rd_data[%0d]", a), v, mval[front][a]);
    end
    read_nib(NIBBLES, v);
    checkOutput("rd_data_oob96", v, 0);
    read_nib(127, v);
    checkOutput("rd_data_oob127", v, 0);
  endtask

  task automatic frame_end();
    repeat (2) @(negedge clk);
    bus.write = 1'b0;
    bus.cs    = 1'b1;
    repeat (8) @(negedge clk);
    model_frame();
    check_frame();
  endtask

  task automatic applyStimulus();
    frame_start();
    foreach (pat[i]) send_bit(pat[i]);
    frame_end();
    pat.delete();
  endtask

  initial begin
    int v, exp_mid, kind;
    bus.cs = 1'b1;
    bus.write = 1'b0;
    bus.data = 1'b0;
    bus.rd_addr = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_rd_data", int'(bus.rd_data), 0);
    checkOutput("rst_err", int'(bus.err), 0);
    RST = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("idle_frame_done", int'(bus.frame_done), 0);
    checkOutput("idle_cmd_valid", int'(bus.cmd_valid), 0);
    checkOutput("idle_frame_nibs", int'(bus.frame_nibs), 0);
    checkOutput("idle_cmd_code", int'(bus.cmd_code), 0);
    checkOutput("idle_err", int'(bus.err), 0);
    read_nib(100, v);
    checkOutput("idle_rd_oob", v, 0);

    // full frame of 0xA5
    push_pat(5, 3);
    push_pat(0, 7);
    for (int i = 0; i < 48; i++) push_pat(8'hA5, 8);
    applyStimulus();

    // read of address 0 while a new frame is still open
    frame_start();
    send_val(5, 3);
    send_val(0, 7);
    send_val(8'h3C, 8);
    repeat (3) @(negedge clk);
    read_nib(0, v);
`ifdef HT_RX_DOUBLE_BUF_EN
    exp_mid = mval[front][0];
`else
    exp_mid = 3;
`endif
    checkOutput("mid_frame_rd0", v, exp_mid);
    send_val(8'h96, 8);
    frame_end();

    push_pat(5, 3);
    push_pat(94, 7);
    push_pat(16'h1234, 16);
    applyStimulus();

    push_pat(4, 3);
    push_pat(9'b000000011, 9);
    push_pat(9'b100000001, 9);
    applyStimulus();

    push_pat(6, 3);
    push_pat(int'($urandom_range(0, 1048575)), 20);
    applyStimulus();

    push_pat(5, 3);
    push_pat(5, 7);
    push_pat(int'($urandom_range(0, 63)), 6);
    applyStimulus();

    for (int f = 0; f < 16; f++) begin
      kind = int'($urandom_range(0, 3));
      if (kind <= 1) begin
        push_pat(5, 3);
        if ($urandom_range(0, 3) == 0) push_pat(int'($urandom_range(88, 127)), 7);
        else push_pat(int'($urandom_range(0, 95)), 7);
        for (int k = int'($urandom_range(0, 24)); k > 0; k--) push_pat(int'($urandom_range(0, 15)), 4);
        push_pat(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
      end else if (kind == 2) begin
        push_pat(4, 3);
        for (int k = int'($urandom_range(1, 3)); k > 0; k--) push_pat(int'($urandom_range(0, 511)), 9);
        push_pat(int'($urandom_range(0, 15)), int'($urandom_range(0, 4)));
      end else begin
        push_pat(int'($urandom_range(0, 7)), 3);
        push_pat(int'($urandom_range(0, 65535)), int'($urandom_range(0, 16)));
      end
      applyStimulus();
    end

    // reset in the middle of a write frame
    frame_start();
    send_val(5, 3);
    send_val(5, 7);
    send_val(int'($urandom_range(0, 511)), 9);
    @(negedge clk);
    RST = 1'b0;
    repeat (2) @(negedge clk);
    bus.cs = 1'b1;
    bus.write = 1'b0;
    repeat (2) @(negedge clk);
    RST = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("rstmid_done_count", done_cnt, exp_done);
    checkOutput("rstmid_err", int'(bus.err), 0);
    checkOutput("rstmid_frame_nibs", int'(bus.frame_nibs), 0);
    checkOutput("rstmid_cmd_code", int'(bus.cmd_code), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
